// File: rtl/trivial_rotator_sdf.sv
// Trivial-twiddle rotator for a radix-2^2 SDF FFT/IFFT stage.
// Multiplies the last quarter of each block by -j (FFT) or +j (IFFT) with saturating negation.
module trivial_rotator_sdf #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int BLOCK_LEN    = 16,
  parameter int NFFT         = 64,
  parameter int LATENCY      = 1,
  localparam int DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sync,
  input  logic                         inverse,
  input  logic signed [DATA_WIDTH-1:0] in_r,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  output logic                         out_valid,
  output logic                         out_sync,
  output logic signed [DATA_WIDTH-1:0] out_r,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic                         out_sat
);

  localparam int IdxW = $clog2(BLOCK_LEN);
  localparam logic signed [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MaxVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  if ((BLOCK_LEN & (BLOCK_LEN - 1)) != 0) begin : g_bad_pow2
    $error("BLOCK_LEN must be a power of two");
  end
  if (BLOCK_LEN < 4 || BLOCK_LEN > NFFT) begin : g_bad_len
    $error("BLOCK_LEN must lie in 4..NFFT");
  end
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_lat
    $error("LATENCY must lie in 1..3");
  end

  // Sample index within the current block
  logic [IdxW-1:0] cnt_q, cnt_d, idx;
  logic            rotate;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = in_sync ? IdxW'(1) : cnt_q + IdxW'(1);
    end
  end

  assign idx    = in_sync ? '0 : cnt_q;
  assign rotate = (idx[IdxW-1 -: 2] == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturating negation: only the most negative value cannot be negated exactly
  logic signed [DATA_WIDTH-1:0] neg_r, neg_i;
  logic                         sat_r, sat_i;

  assign sat_r = (in_r == MinVal);
  assign sat_i = (in_i == MinVal);
  assign neg_r = sat_r ? MaxVal : -in_r;
  assign neg_i = sat_i ? MaxVal : -in_i;

  logic signed [DATA_WIDTH-1:0] rot_r, rot_i;
  logic                         rot_sat;

  always_comb begin
    rot_r   = in_r;
    rot_i   = in_i;
    rot_sat = 1'b0;
    if (rotate) begin
      if (inverse) begin
        rot_r   = neg_i;
        rot_i   = in_r;
        rot_sat = sat_i;
      end else begin
        rot_r   = in_i;
        rot_i   = neg_r;
        rot_sat = sat_r;
      end
    end
  end

  // Delay line: valid always shifts, payload only loads behind a valid so bubbles hold data
  logic [LATENCY-1:0]           vld_q, sync_q, sat_q;
  logic signed [DATA_WIDTH-1:0] r_q [LATENCY];
  logic signed [DATA_WIDTH-1:0] i_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      sync_q <= '0;
      sat_q  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_q[k] <= '0;
        i_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        r_q[0]    <= rot_r;
        i_q[0]    <= rot_i;
        sat_q[0]  <= rot_sat;
        sync_q[0] <= in_sync;
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          r_q[k]    <= r_q[k-1];
          i_q[k]    <= i_q[k-1];
          sat_q[k]  <= sat_q[k-1];
          sync_q[k] <= sync_q[k-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_sync  = sync_q[LATENCY-1];
  assign out_sat   = sat_q[LATENCY-1];
  assign out_r     = r_q[LATENCY-1];
  assign out_i     = i_q[LATENCY-1];

endmodule

// File: tb/tb_trivial_rotator_sdf.sv
// Scoreboard bench: two rotators (LATENCY 1 and 3) share stimulus; a monitor checks each
// against a block-index model of the rotation rules.
module tb_trivial_rotator_sdf;

  localparam int BL  = 16;
  localparam int DW  = 18;
  localparam int MIN = -(1 << (DW - 1));
  localparam int MAX = (1 << (DW - 1)) - 1;
  localparam int LATS [2] = '{1, 3};

  typedef struct {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
    logic                 sat;
    logic                 sync;
    int                   due;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0, in_sync = 1'b0, inverse = 1'b0;
  logic signed [DW-1:0] in_r = '0, in_i = '0;

  logic                 ov  [2];
  logic                 osy [2];
  logic                 os  [2];
  logic signed [DW-1:0] orr [2];
  logic signed [DW-1:0] oi  [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;
  exp_t q [2][$];
  exp_t last [2];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    trivial_rotator_sdf #(
      .INTEGER_SIZE(6), .FRACT_SIZE(12), .BLOCK_LEN(BL), .NFFT(64), .LATENCY(LATS[g])
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .inverse(inverse),
      .in_r(in_r), .in_i(in_i), .out_valid(ov[g]), .out_sync(osy[g]), .out_r(orr[g]),
      .out_i(oi[g]), .out_sat(os[g])
    );
  end

  function automatic void chk(string name, int d, logic [DW-1:0] got, logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s lat=%0d cyc=%0d got=%0h want=%0h", name, LATS[d], cyc, got, want);
    end
  endfunction

  function automatic int neg(int x);
    return (x == MIN) ? MAX : -x;
  endfunction

  task automatic clear_model();
    model_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      last[d] = '{r: '0, i: '0, sat: 1'b0, sync: 1'b0, due: 0};
    end
  endtask

  // Reference: index from sync/wrap rules, rotation in the last quarter of the block
  task automatic drive(input logic v, input logic s, input logic inv, input int r, input int i);
    int   idx, er, ei;
    logic rot, esat;
    exp_t x;
    @(posedge clk);
    #1;
    in_valid = v; in_sync = s; inverse = inv;
    in_r = DW'(r); in_i = DW'(i);
    if (v) begin
      r = int'(in_r); i = int'(in_i);
      idx = s ? 0 : model_cnt;
      model_cnt = s ? 1 : (model_cnt + 1) % BL;
      rot = (idx >= 3 * BL / 4);
      er = r; ei = i; esat = 1'b0;
      if (rot && !inv) begin er = i;      ei = neg(r); esat = (r == MIN); end
      if (rot && inv)  begin er = neg(i); ei = r;      esat = (i == MIN); end
      for (int d = 0; d < 2; d++) begin
        x = '{r: DW'(er), i: DW'(ei), sat: esat, sync: s, due: cyc + LATS[d]};
        q[d].push_back(x);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0 && q[d][0].due == cyc) begin
        e = q[d].pop_front();
        chk("out_valid", d, DW'(ov[d]), DW'(1));
        chk("out_r", d, orr[d], e.r);
        chk("out_i", d, oi[d], e.i);
        chk("out_sat", d, DW'(os[d]), DW'(e.sat));
        chk("out_sync", d, DW'(osy[d]), DW'(e.sync));
        last[d] = e;
      end else begin
        chk("bubble_valid", d, DW'(ov[d]), DW'(0));
        chk("hold_r", d, orr[d], last[d].r);
        chk("hold_i", d, oi[d], last[d].i);
        chk("hold_sat", d, DW'(os[d]), DW'(last[d].sat));
        chk("hold_sync", d, DW'(osy[d]), DW'(last[d].sync));
      end
    end
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Ramp over two blocks
    for (int k = 0; k < 32; k++) drive(1'b1, k == 0, 1'b0, k, 100 + k);
    drive(1'b0, 1'b0, 1'b0, 0, 0);

    // +j and -j at index 13
    for (int inv = 1; inv >= 0; inv--) begin
      for (int k = 0; k < 14; k++) begin
        drive(1'b1, k == 0, inv[0], (k == 13) ? 5 : k, (k == 13) ? -7 : 0);
      end
    end

    // Saturating negation across a whole block
    for (int k = 0; k < BL; k++) drive(1'b1, k == 0, 1'b0, MIN, 3);
    for (int k = 0; k < BL; k++) drive(1'b1, k == 0, 1'b1, 9, MIN);

    // Bubbles: 1,0,0,1,1
    drive(1'b1, 1'b1, 1'b0, 1, 2);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 3, 4);
    drive(1'b1, 1'b0, 1'b0, 5, 6);

    // Mid-block resync at index 7, then run past the rotation zone
    for (int k = 0; k < 22; k++) drive(1'b1, k == 0 || k == 7, 1'b0, k, -k);

    // Reset mid-frame: outputs clear asynchronously, counter restarts at index 0
    for (int k = 0; k < 14; k++) drive(1'b1, k == 0, 1'b0, 40 + k, 50 + k);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    clear_model();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, DW'(ov[d]), DW'(0));
      chk("rst_r", d, orr[d], DW'(0));
      chk("rst_i", d, oi[d], DW'(0));
      chk("rst_sat", d, DW'(os[d]), DW'(0));
      chk("rst_sync", d, DW'(osy[d]), DW'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 1'b0, 200 + k, 300 + k);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
            ($urandom_range(0, 7) == 0) ? MIN : int'($urandom),
            ($urandom_range(0, 7) == 0) ? MIN : int'($urandom));
    end

    for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) chk("drained", d, DW'(q[d].size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
